hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline sequencing controller for the five-stage RV32I core. Per cycle it decides, for every pipeline register, whether it loads normally, flushes to a bubble or holds. It raises the PC enable and the EX operand forwarding selects. It also tracks data-memory wait states, with a watchdog and saturating stall/flush counters for performance visibility.

## Interface
- `REG_ADDR_W`, 5: register address width.
- `CNT_W`, 32: width of performance counters.
- `WAIT_W`, 8: width of the memory-wait watchdog counter.
- `TIMEOUT`, 255: consecutive freeze cycles that trip the watchdog; must be ≤ 2^WAIT_W−1.
- Clock/reset: one clock. Reset is asynchronous and active-low.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `rs1_ID`, `rs2_ID` in REG_ADDR_W: source registers of the instruction in ID.
- `use_rs1_ID`, `use_rs2_ID` in 1: ID instruction actually reads rs1/rs2.
- `rs1_EX`, `rs2_EX` in REG_ADDR_W: source registers of the instruction in EX.
- `rd_EX` in REG_ADDR_W, `memread_EX` in 1: destination and load flag in EX.
- `rd_MEM` in REG_ADDR_W, `regwrite_MEM` in 1, `memaccess_MEM` in 1: MEM-stage destination, write enable, load/store flag.
- `rd_WB` in REG_ADDR_W, `regwrite_WB` in 1: WB-stage destination and write enable.
- `pc_sel` in 1: taken branch/jump resolved in EX.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `pc_en` out 1: PC register loads.
- `if_id_sel`, `id_ex_sel`, `ex_mem_sel`, `mem_wb_sel` out 3: one-hot register control. 001 = normal, 010 = flush, 100 = stall.
- `fwd_a`, `fwd_b` out 2: ALU operand source. 00 = regfile, 01 = WB, 10 = MEM.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating performance counters.
- `timeout_err` out 1: sticky watchdog flag.

## Operation
- Freeze condition: `memaccess_MEM && !dmem_ready`.
  - `pc_en`=0.
  - IF/ID, ID/EX and EX/MEM are set to stall.
  - MEM/WB is set to flush, so WB does not repeat a write.
- Branch flush condition: `pc_sel`.
  - `pc_en`=1.
  - IF/ID and ID/EX are set to flush.
  - EX/MEM and MEM/WB are set to normal.
- Load-use condition: `memread_EX && rd_EX!=0` and the ID instruction reads `rd_EX` (`use_rsX_ID && rsX_ID==rd_EX`).
  - `pc_en`=0.
  - IF/ID is set to stall.
  - ID/EX is set to flush.
  - EX/MEM and MEM/WB are set to normal.
- Otherwise all four selects are normal and `pc_en`=1.
- Priority is freeze > branch flush > load-use > normal.
  - A `pc_sel` during freeze is held, not lost, because EX is held. It takes effect on the first non-frozen cycle.
- Forwarding (operand a; operand b is the same with rs2):
  - 10 if `regwrite_MEM && rd_MEM!=0 && rd_MEM==rs1_EX`.
  - Else 01 if the same test passes on WB.
  - Else 00.
  - MEM wins over WB. Register x0 is never forwarded.
- FSM has two states, RUN and MEM_WAIT.
  - RUN → MEM_WAIT when freeze is seen at a clock edge.
  - MEM_WAIT → RUN on the first edge without freeze.
  - The freeze outputs are combinational from the condition, so the first wait cycle is covered while still in RUN.
- Watchdog:
  - `wait_cnt` increments on each edge that sees freeze. It clears on any edge without freeze.
  - When `wait_cnt` reaches TIMEOUT, `timeout_err` is set and stays set until reset. Outputs are otherwise unaffected.
- Counters:
  - `stall_cnt` +1 on every edge with `pc_en`=0 (freeze or load-use).
  - `flush_cnt` +1 on every edge where the branch flush is applied.
  - Both saturate at all-ones.

## Timing
- All selects, `pc_en` and forwarding are combinational from inputs in the same cycle. Registers act at the next rising edge. Controller latency is zero cycles.
- A load-use stall lasts exactly one cycle: the bubble reaches EX and the load reaches MEM, which clears the condition.
- While `reset` is low:
  - `pc_en`=0 and all four selects = 010 (flush).
  - `fwd_a`=`fwd_b`=00.
  - FSM is in RUN; `wait_cnt`, `stall_cnt` and `flush_cnt` are 0; `timeout_err`=0.
- Reset asserted mid-wait clears everything immediately, asynchronously. Reset deassertion is synchronised externally.

## Structure
- Package `rv_pipe_pkg` holds:
  - `SEL_NORMAL`/`SEL_FLUSH`/`SEL_STALL` constants;
  - the `fwd_sel_t` enum (REGF, WB, MEM);
  - the `hz_state_t` enum (RUN, MEM_WAIT).
- Sub-module `fwd_unit`: pure combinational forwarding for one operand, instantiated twice.

## Test plan
- Load-use: `lw x5` in EX, ID `add x6,x5,x1` with `use_rs1_ID`=1 → one cycle with `pc_en`=0, `if_id_sel`=100, `id_ex_sel`=010; `stall_cnt` 0→1. Same case with `rd_EX`=0 → no stall.
- Branch: `pc_sel`=1 for one cycle → `if_id_sel`=`id_ex_sel`=010, `pc_en`=1; `flush_cnt` 0→1.
- Forwarding: `rd_MEM`=`rd_WB`=`rs1_EX`=7, both regwrite=1 → `fwd_a`=10. `rd_MEM`=0 → `fwd_a`=01. With `rs2_EX`=0 → `fwd_b`=00.
- Freeze with simultaneous `pc_sel`: `dmem_ready`=0 for 3 cycles → 3 cycles with all upstream selects = 100, `mem_wb_sel`=010, no flush. Cycle 4 → flush applied; `stall_cnt`=3, `flush_cnt`=1.
- Watchdog: `dmem_ready` held low 255 cycles → `timeout_err` rises at the 255th edge and stays high after `dmem_ready`=1.
- Reset mid-MEM_WAIT: drop `reset` → immediately `pc_en`=0, all selects 010, counters and `timeout_err` = 0. State is RUN after release.

Source files
------------

// File: rtl/rv_pipe_pkg.sv
// Shared pipeline-control types for the five-stage RV32I core.
//   SEL_*      : one-hot pipeline register controls (normal / flush / stall)
//   fwd_sel_t  : EX operand source (regfile, WB result, MEM result)
//   hz_state_t : hazard controller memory-wait state
package rv_pipe_pkg;

    localparam logic [2:0] SEL_NORMAL = 3'b001;
    localparam logic [2:0] SEL_FLUSH  = 3'b010;
    localparam logic [2:0] SEL_STALL  = 3'b100;

    typedef enum logic [1:0] {
        REGF = 2'b00,
        WB   = 2'b01,
        MEM  = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle.
//   master : pipeline side, drives stage info, consumes register controls
//   slave  : hazard controller
// Stage info : rs1/rs2 (ID, EX), rd/flags (EX, MEM, WB), pc_sel, dmem_ready
// Controls   : pc_en, four *_sel one-hot controls, fwd_a/fwd_b
// Status     : stall_cnt, flush_cnt, timeout_err
interface hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) ();
    logic [REG_ADDR_W-1:0] rs1_ID, rs2_ID;
    logic                  use_rs1_ID, use_rs2_ID;
    logic [REG_ADDR_W-1:0] rs1_EX, rs2_EX, rd_EX;
    logic                  memread_EX;
    logic [REG_ADDR_W-1:0] rd_MEM;
    logic                  regwrite_MEM, memaccess_MEM;
    logic [REG_ADDR_W-1:0] rd_WB;
    logic                  regwrite_WB;
    logic                  pc_sel;
    logic                  dmem_ready;

    logic                  pc_en;
    logic [2:0]            if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel;
    logic [1:0]            fwd_a, fwd_b;
    logic [CNT_W-1:0]      stall_cnt, flush_cnt;
    logic                  timeout_err;

    modport master (
        output rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID,
               rs1_EX, rs2_EX, rd_EX, memread_EX,
               rd_MEM, regwrite_MEM, memaccess_MEM,
               rd_WB, regwrite_WB, pc_sel, dmem_ready,
        input  pc_en, if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel,
               fwd_a, fwd_b, stall_cnt, flush_cnt, timeout_err
    );

    modport slave (
        input  rs1_ID, rs2_ID, use_rs1_ID, use_rs2_ID,
               rs1_EX, rs2_EX, rd_EX, memread_EX,
               rd_MEM, regwrite_MEM, memaccess_MEM,
               rd_WB, regwrite_WB, pc_sel, dmem_ready,
        output pc_en, if_id_sel, id_ex_sel, ex_mem_sel, mem_wb_sel,
               fwd_a, fwd_b, stall_cnt, flush_cnt, timeout_err
    );
endinterface

// File: rtl/fwd_unit.sv
// Forwarding select for one EX operand.
//   rs           : source register of the EX instruction
//   rd_mem/wb    : destination of the MEM / WB instruction
//   regwrite_*   : that instruction writes the register file
//   sel          : MEM beats WB beats regfile; x0 never forwarded
module fwd_unit
    import rv_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] rd_mem,
    input  logic                  regwrite_mem,
    input  logic [REG_ADDR_W-1:0] rd_wb,
    input  logic                  regwrite_wb,
    output fwd_sel_t              sel
);
    always_comb begin
        sel = REGF;
        if (regwrite_mem && (rd_mem != '0) && (rd_mem == rs))
            sel = MEM;
        else if (regwrite_wb && (rd_wb != '0) && (rd_wb == rs))
            sel = WB;
    end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage RV32I core.
//   clk, reset  : core clock, asynchronous active-low reset
//   hz (slave)  : stage info in; pc_en, register controls, forwarding selects,
//                 saturating stall/flush counters and sticky watchdog flag out
// Controls are combinational (zero latency); priority is
// memory freeze > branch flush > load-use > normal.
module hazard_ctrl
    import rv_pipe_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    parameter int WAIT_W     = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          reset,
    hazard_ctrl_if.slave  hz
);
    localparam logic [WAIT_W-1:0] TO_VAL = WAIT_W'(TIMEOUT);

    hz_state_t         state, state_nxt;
    logic              freeze, branch, load_use;
    fwd_sel_t          fwd_a_raw, fwd_b_raw;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0]  stall_q, flush_q;
    logic              err_q;

    assign freeze   = hz.memaccess_MEM && !hz.dmem_ready;
    // While frozen EX is held, so a pending pc_sel is simply applied later.
    assign branch   = hz.pc_sel && !freeze;
    assign load_use = hz.memread_EX && (hz.rd_EX != '0) &&
                      ((hz.use_rs1_ID && (hz.rs1_ID == hz.rd_EX)) ||
                       (hz.use_rs2_ID && (hz.rs2_ID == hz.rd_EX)));

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .rs(hz.rs1_EX), .rd_mem(hz.rd_MEM), .regwrite_mem(hz.regwrite_MEM),
        .rd_wb(hz.rd_WB), .regwrite_wb(hz.regwrite_WB), .sel(fwd_a_raw)
    );

    fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .rs(hz.rs2_EX), .rd_mem(hz.rd_MEM), .regwrite_mem(hz.regwrite_MEM),
        .rd_wb(hz.rd_WB), .regwrite_wb(hz.regwrite_WB), .sel(fwd_b_raw)
    );

    always_comb begin
        hz.pc_en      = 1'b1;
        hz.if_id_sel  = SEL_NORMAL;
        hz.id_ex_sel  = SEL_NORMAL;
        hz.ex_mem_sel = SEL_NORMAL;
        hz.mem_wb_sel = SEL_NORMAL;
        hz.fwd_a      = fwd_a_raw;
        hz.fwd_b      = fwd_b_raw;
        if (!reset) begin
            hz.pc_en      = 1'b0;
            hz.if_id_sel  = SEL_FLUSH;
            hz.id_ex_sel  = SEL_FLUSH;
            hz.ex_mem_sel = SEL_FLUSH;
            hz.mem_wb_sel = SEL_FLUSH;
            hz.fwd_a      = REGF;
            hz.fwd_b      = REGF;
        end else if (freeze) begin
            hz.pc_en      = 1'b0;
            hz.if_id_sel  = SEL_STALL;
            hz.id_ex_sel  = SEL_STALL;
            hz.ex_mem_sel = SEL_STALL;
            // Bubble into WB so the held MEM instruction is not written twice.
            hz.mem_wb_sel = SEL_FLUSH;
        end else if (branch) begin
            hz.if_id_sel  = SEL_FLUSH;
            hz.id_ex_sel  = SEL_FLUSH;
        end else if (load_use) begin
            hz.pc_en      = 1'b0;
            hz.if_id_sel  = SEL_STALL;
            hz.id_ex_sel  = SEL_FLUSH;
        end
    end

    // State tracks the wait; outputs do not depend on it, so the first
    // wait cycle is handled while still in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:      if (freeze)  state_nxt = MEM_WAIT;
            MEM_WAIT: if (!freeze) state_nxt = RUN;
            default:  state_nxt = RUN;
        endcase
    end

    // Watchdog count saturates at TIMEOUT; the flag latches on reaching it.
    always_comb begin
        wait_nxt = '0;
        if (freeze)
            wait_nxt = (wait_cnt == TO_VAL) ? wait_cnt : wait_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            wait_cnt <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if (freeze && (wait_nxt == TO_VAL))
                err_q <= 1'b1;
            if (!hz.pc_en && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (branch && (flush_q != '1))
                flush_q <= flush_q + 1'b1;
        end
    end

    assign hz.stall_cnt   = stall_q;
    assign hz.flush_cnt   = flush_q;
    assign hz.timeout_err = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    import rv_pipe_pkg::*;

    localparam int TMO = 255;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) hz ();

    hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(32), .WAIT_W(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .hz(hz)
    );

    typedef struct {
        bit       rst_n;
        bit [4:0] rs1_id, rs2_id;
        bit       use1, use2;
        bit [4:0] rs1_ex, rs2_ex, rd_ex;
        bit       memread;
        bit [4:0] rd_mem;
        bit       rw_mem, macc;
        bit [4:0] rd_wb;
        bit       rw_wb, pc_sel, ready;
    } stim_t;

    typedef struct {
        bit       pc_en;
        bit [2:0] s_ifid, s_idex, s_exmem, s_memwb;
        bit [1:0] fa, fb;
        longint   stall, flush;
        bit       err;
    } exp_t;

    exp_t   q[$];
    int     n_checks = 0;
    int     n_fail   = 0;

    // Reference model state
    stim_t  cur;
    longint m_stall, m_flush;
    int     m_wait;
    bit     m_err;
    localparam longint CMAX = 64'h0000_0000_FFFF_FFFF;

    function automatic bit [1:0] ref_fwd(bit [4:0] r, stim_t s);
        if (s.rw_mem && s.rd_mem != 0 && s.rd_mem == r) return 2'b10;
        if (s.rw_wb && s.rd_wb != 0 && s.rd_wb == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t ref_comb(stim_t s);
        exp_t e;
        bit frz, lu;
        e = '{pc_en: 1, s_ifid: 3'b001, s_idex: 3'b001, s_exmem: 3'b001,
              s_memwb: 3'b001, fa: 0, fb: 0, stall: 0, flush: 0, err: 0};
        frz = s.macc && !s.ready;
        lu  = s.memread && s.rd_ex != 0 &&
              ((s.use1 && s.rs1_id == s.rd_ex) || (s.use2 && s.rs2_id == s.rd_ex));
        if (!s.rst_n) begin
            e.pc_en = 0;
            e.s_ifid = 3'b010; e.s_idex = 3'b010; e.s_exmem = 3'b010; e.s_memwb = 3'b010;
            return e;
        end
        if (frz) begin
            e.pc_en = 0;
            e.s_ifid = 3'b100; e.s_idex = 3'b100; e.s_exmem = 3'b100; e.s_memwb = 3'b010;
        end else if (s.pc_sel) begin
            e.s_ifid = 3'b010; e.s_idex = 3'b010;
        end else if (lu) begin
            e.pc_en = 0;
            e.s_ifid = 3'b100; e.s_idex = 3'b010;
        end
        e.fa = ref_fwd(s.rs1_ex, s);
        e.fb = ref_fwd(s.rs2_ex, s);
        return e;
    endfunction

    // Account for the rising edge that just happened under the inputs of 'cur'.
    task automatic model_edge();
        exp_t e;
        bit frz;
        if (!cur.rst_n) return;
        e   = ref_comb(cur);
        frz = cur.macc && !cur.ready;
        if (!e.pc_en && m_stall < CMAX) m_stall++;
        if (cur.pc_sel && !frz && m_flush < CMAX) m_flush++;
        if (frz) begin
            if (m_wait < TMO) m_wait++;
            if (m_wait == TMO) m_err = 1;
        end else begin
            m_wait = 0;
        end
    endtask

    task automatic drive(stim_t s);
        reset            = s.rst_n;
        hz.rs1_ID        = s.rs1_id;
        hz.rs2_ID        = s.rs2_id;
        hz.use_rs1_ID    = s.use1;
        hz.use_rs2_ID    = s.use2;
        hz.rs1_EX        = s.rs1_ex;
        hz.rs2_EX        = s.rs2_ex;
        hz.rd_EX         = s.rd_ex;
        hz.memread_EX    = s.memread;
        hz.rd_MEM        = s.rd_mem;
        hz.regwrite_MEM  = s.rw_mem;
        hz.memaccess_MEM = s.macc;
        hz.rd_WB         = s.rd_wb;
        hz.regwrite_WB   = s.rw_wb;
        hz.pc_sel        = s.pc_sel;
        hz.dmem_ready    = s.ready;
    endtask

    task automatic apply(stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        model_edge();
        cur = s;
        drive(s);
        if (!s.rst_n) begin
            m_stall = 0; m_flush = 0; m_wait = 0; m_err = 0;
        end
        e       = ref_comb(s);
        e.stall = m_stall;
        e.flush = m_flush;
        e.err   = m_err;
        q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '{rst_n: 1, rs1_id: 0, rs2_id: 0, use1: 0, use2: 0, rs1_ex: 0, rs2_ex: 0,
              rd_ex: 0, memread: 0, rd_mem: 0, rw_mem: 0, macc: 0, rd_wb: 0,
              rw_wb: 0, pc_sel: 0, ready: 1};
        return s;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected response per cycle, compared away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc_en",       longint'(hz.pc_en),       longint'(e.pc_en));
            chk("if_id_sel",   longint'(hz.if_id_sel),   longint'(e.s_ifid));
            chk("id_ex_sel",   longint'(hz.id_ex_sel),   longint'(e.s_idex));
            chk("ex_mem_sel",  longint'(hz.ex_mem_sel),  longint'(e.s_exmem));
            chk("mem_wb_sel",  longint'(hz.mem_wb_sel),  longint'(e.s_memwb));
            chk("fwd_a",       longint'(hz.fwd_a),       longint'(e.fa));
            chk("fwd_b",       longint'(hz.fwd_b),       longint'(e.fb));
            chk("stall_cnt",   longint'(hz.stall_cnt),   e.stall);
            chk("flush_cnt",   longint'(hz.flush_cnt),   e.flush);
            chk("timeout_err", longint'(hz.timeout_err), longint'(e.err));
        end
    end

    initial begin
        stim_t s;
        m_stall = 0; m_flush = 0; m_wait = 0; m_err = 0;
        cur = idle();
        cur.rst_n = 0;
        drive(cur);

        // Reset held
        repeat (3) apply(cur);
        apply(idle());

        // Load-use: lw x5 in EX, add x6,x5,x1 in ID
        s = idle(); s.memread = 1; s.rd_ex = 5; s.rs1_id = 5; s.use1 = 1; s.rs2_id = 1; s.use2 = 1;
        apply(s);
        apply(idle());
        // Same with rd_EX = x0: no stall
        s = idle(); s.memread = 1; s.rd_ex = 0; s.rs1_id = 0; s.use1 = 1;
        apply(s);

        // Branch flush for one cycle
        s = idle(); s.pc_sel = 1;
        apply(s);
        apply(idle());

        // Forwarding: MEM beats WB, then WB, x0 never forwarded
        s = idle(); s.rd_mem = 7; s.rd_wb = 7; s.rs1_ex = 7; s.rw_mem = 1; s.rw_wb = 1;
        apply(s);
        s.rd_mem = 0;
        apply(s);
        s.rs2_ex = 0; s.rd_wb = 0;
        apply(s);

        // Freeze with pending branch: 3 frozen cycles then flush applied
        s = idle(); s.rst_n = 0;
        apply(s);
        s = idle(); s.macc = 1; s.ready = 0; s.pc_sel = 1;
        repeat (3) apply(s);
        s.ready = 1;
        apply(s);
        apply(idle());
        apply(idle());

        // Watchdog: long freeze trips the sticky flag
        s = idle(); s.macc = 1; s.ready = 0;
        repeat (TMO + 5) apply(s);
        repeat (4) apply(idle());

        // Reset dropped in the middle of a wait
        s = idle(); s.macc = 1; s.ready = 0;
        repeat (5) apply(s);
        s.rst_n = 0;
        repeat (2) apply(s);
        s.rst_n = 1;
        apply(s);
        repeat (2) apply(idle());

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            s.rst_n   = ($urandom_range(99) != 0);
            s.rs1_id  = 5'($urandom_range(3));
            s.rs2_id  = 5'($urandom_range(3));
            s.use1    = 1'($urandom);
            s.use2    = 1'($urandom);
            s.rs1_ex  = 5'($urandom_range(3));
            s.rs2_ex  = 5'($urandom_range(3));
            s.rd_ex   = 5'($urandom_range(3));
            s.memread = 1'($urandom);
            s.rd_mem  = 5'($urandom_range(3));
            s.rw_mem  = 1'($urandom);
            s.macc    = 1'($urandom);
            s.rd_wb   = 5'($urandom_range(3));
            s.rw_wb   = 1'($urandom);
            s.pc_sel  = ($urandom_range(6) == 0);
            s.ready   = ($urandom_range(9) < 7);
            apply(s);
        end

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d responses left, expected 0", q.size());
        end
        #20;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
